multiplier_seq: RTL and testbench

MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

---
 rtl/multiplier_seq_pkg.sv | 14 +
 rtl/multiplier_seq_if.sv | 33 +++
 rtl/multiplier_seq.sv | 121 ++++++++++++
 tb/tb_multiplier_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_seq_pkg.sv
// Shared definitions for the sequential repeated-addition multiplier.
package mul_pkg;

   // Default operand width; the product is twice this wide.
   localparam int WIDTH_DEFAULT = 7;

   // One-hot controller states.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      LOAD = 3'b010,
      ADD  = 3'b100
   } state_t;

endpackage : mul_pkg

// File: rtl/multiplier_seq_if.sv
// Request/response bundle between a multiply requester and multiplier_seq.
interface multiplier_seq_if #(
   parameter int WIDTH = mul_pkg::WIDTH_DEFAULT
);

   logic                 start_i;
   logic [WIDTH-1:0]     multiplicand_i;
   logic [WIDTH-1:0]     multiplier_i;
   logic                 busy_o;
   logic                 done_o;
   logic [2*WIDTH-1:0]   product_o;

   // Requester side: issues operands, observes status and result.
   modport master (
      output start_i,
      output multiplicand_i,
      output multiplier_i,
      input  busy_o,
      input  done_o,
      input  product_o
   );

   // Multiplier side.
   modport slave (
      input  start_i,
      input  multiplicand_i,
      input  multiplier_i,
      output busy_o,
      output done_o,
      output product_o
   );

endinterface : multiplier_seq_if

// File: rtl/multiplier_seq.sv
// Sequential unsigned multiplier: adds the larger operand into an accumulator
// as many times as the smaller operand, so latency is min(A,B)+2 cycles.
module multiplier_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   multiplier_seq_if.slave bus
);

   localparam int PW = 2 * WIDTH;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] addend_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    product_q;
   logic             busy_q;
   logic             done_q;

   logic             accept;
   logic             load_en;
   logic             add_en;
   logic             finish;
   logic             busy_d;
   logic             cnt_zero;
   logic             a_ge_b;

   assign cnt_zero = (cnt_q == '0);
   // Ties favour op_a as the addend; the count is the same value either way.
   assign a_ge_b   = (op_a_q >= op_b_q);

   // State register; reset wins over any request on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: flops take non-blocking assignments so every register samples
      // pre-edge values regardless of process evaluation order.
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; any non-one-hot encoding falls back to IDLE.
   always_comb begin
      // NOTE: a default ahead of the case keeps every path assigned, so no
      // latch is inferred.
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = bus.start_i ? LOAD : IDLE;
         LOAD:    state_d = ADD;
         ADD:     state_d = cnt_zero ? IDLE : ADD;
         default: state_d = IDLE;
      endcase
   end

   // Per-state datapath strobes and the next value of the busy flag.
   always_comb begin
      accept  = 1'b0;
      load_en = 1'b0;
      add_en  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE:    accept = bus.start_i;
         LOAD:    load_en = 1'b1;
         ADD: begin
            add_en = !cnt_zero;
            finish = cnt_zero;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Datapath and registered outputs: capture, min/max load, add, publish.
   always_ff @(posedge clk) begin
      // NOTE: every datapath register is reset, so an aborted operation
      // leaves no stale operands, count or product behind.
      if (rst) begin
         op_a_q    <= '0;
         op_b_q    <= '0;
         cnt_q     <= '0;
         addend_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= finish;
         busy_q <= busy_d;
         if (accept) begin
            op_a_q <= bus.multiplicand_i;
            op_b_q <= bus.multiplier_i;
            acc_q  <= '0;
         end
         if (load_en) begin
            cnt_q    <= a_ge_b ? op_b_q : op_a_q;
            addend_q <= a_ge_b ? op_a_q : op_b_q;
         end
         if (add_en) begin
            // max*min < 2^(2*WIDTH), so this sum never wraps.
            acc_q <= acc_q + {{WIDTH{1'b0}}, addend_q};
            cnt_q <= cnt_q - WIDTH'(1);
         end
         if (finish) begin
            product_q <= acc_q;
         end
      end
   end

   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.product_o = product_q;

endmodule : multiplier_seq

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq: directed table, corner sequences
// and randomised back-to-back operations against an arithmetic model.
module tb_multiplier_seq;

   localparam int WIDTH = 7;
   localparam int MAXV  = (1 << WIDTH) - 1;
   localparam int BUDGET = 300;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   multiplier_seq_if #(.WIDTH(WIDTH)) bus ();

   multiplier_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string name;
      int    a;
      int    b;
      int    prod;
      int    lat;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for one edge (the accept edge E0), then
   // scramble the operand inputs so in-flight results must not depend on them.
   task automatic launch(input int a, input int b);
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      av = a[WIDTH-1:0];
      bv = b[WIDTH-1:0];
      bus.start_i        = 1'b1;
      bus.multiplicand_i = av;
      bus.multiplier_i   = bv;
      tick();
      bus.start_i        = 1'b0;
      bus.multiplicand_i = WIDTH'($urandom);
      bus.multiplier_i   = WIDTH'($urandom);
   endtask

   // Wait (bounded) for done_o after a launch; check latency, product, busy.
   task automatic wait_done(input string name, input int exp_prod, input int exp_lat);
      int lat;
      int busy_ok;
      lat = -1;
      busy_ok = bus.busy_o ? 1 : 0;
      for (int k = 1; k <= BUDGET; k++) begin
         tick();
         if (bus.done_o) begin
            lat = k;
            break;
         end
         if (!bus.busy_o) busy_ok = 0;
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " product"}, int'(bus.product_o), exp_prod);
      check({name, " busy while running"}, busy_ok, 1);
      check({name, " busy cleared at done"}, int'(bus.busy_o), 0);
   endtask

   // Count done pulses over a quiet window with start held low.
   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         if (bus.done_o) n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      vec_t tbl[7];
      int   n;
      int   k;
      int   a;
      int   b;

      tbl[0] = '{name: "17x3",    a: 17,  b: 3,   prod: 51,    lat: 5};
      tbl[1] = '{name: "0x99",    a: 0,   b: 99,  prod: 0,     lat: 2};
      tbl[2] = '{name: "1x0",     a: 1,   b: 0,   prod: 0,     lat: 2};
      tbl[3] = '{name: "127x127", a: 127, b: 127, prod: 16129, lat: 129};
      tbl[4] = '{name: "127x2",   a: 127, b: 2,   prod: 254,   lat: 4};
      tbl[5] = '{name: "6x7",     a: 6,   b: 7,   prod: 42,    lat: 8};
      tbl[6] = '{name: "3x126",   a: 3,   b: 126, prod: 378,   lat: 5};

      rst                = 1'b1;
      bus.start_i        = 1'b0;
      bus.multiplicand_i = '0;
      bus.multiplier_i   = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset busy", int'(bus.busy_o), 0);
      check("reset done", int'(bus.done_o), 0);
      check("reset product", int'(bus.product_o), 0);

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         launch(tbl[i].a, tbl[i].b);
         wait_done(tbl[i].name, tbl[i].prod, tbl[i].lat);
         tick();
         check({tbl[i].name, " done one cycle"}, int'(bus.done_o), 0);
      end

      // start re-pulsed mid-ADD must be ignored and not queued.
      launch(5, 4);
      k = 0;
      for (int j = 0; j < 3; j++) begin
         tick();
         k++;
      end
      bus.start_i        = 1'b1;
      bus.multiplicand_i = 7'd9;
      bus.multiplier_i   = 7'd9;
      tick();
      k++;
      bus.start_i = 1'b0;
      for (int j = 0; j < BUDGET; j++) begin
         if (bus.done_o) break;
         tick();
         k++;
      end
      check("mid-ADD start latency", k, 6);
      check("mid-ADD start product", int'(bus.product_o), 20);
      count_done(20, n);
      check("mid-ADD start not queued", n, 0);
      check("mid-ADD start idle", int'(bus.busy_o), 0);

      // start on the done cycle is accepted.
      launch(5, 4);
      wait_done("5x4 again", 20, 6);
      launch(9, 9);
      wait_done("9x9 on done cycle", 81, 11);

      // Reset mid-operation aborts with no done pulse.
      launch(10, 10);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", int'(bus.busy_o), 0);
      check("abort done", int'(bus.done_o), 0);
      check("abort product", int'(bus.product_o), 0);
      count_done(20, n);
      check("abort no done", n, 0);
      launch(6, 7);
      wait_done("6x7 after abort", 42, 8);

      // Reset beats start on the same edge.
      rst                = 1'b1;
      bus.start_i        = 1'b1;
      bus.multiplicand_i = 7'd3;
      bus.multiplier_i   = 7'd3;
      tick();
      rst         = 1'b0;
      bus.start_i = 1'b0;
      check("rst over start busy", int'(bus.busy_o), 0);
      count_done(15, n);
      check("rst over start no done", n, 0);

      // Randomised back-to-back operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range(0, MAXV);
         b = $urandom_range(0, MAXV);
         if (i % 8 == 3) a = 0;
         if (i % 8 == 6) b = MAXV;
         launch(a, b);
         wait_done($sformatf("rand %0d (%0dx%0d)", i, a, b), a * b,
                   ((a < b) ? a : b) + 2);
      end
      tick();
      check("final done one cycle", int'(bus.done_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_multiplier_seq
